bus_sink: RTL
=============

# bus_sink

Receiving end of the 4-bit address/data sequence bus driven by the team's pattern generator. Captures each valid addr/data beat into a 16-entry by 4-bit register file, tracks coverage of the address space, and optionally checks the beats against the generator's expected pattern. After the generator releases the bus, a read port allows the captured contents to be inspected.

## Interface
- AW, 4, address width; the file holds 2^AW entries.
- DW, 4, data width.

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- bus_valid  in  1  generator is driving a valid beat this cycle
- bus_addr  in  AW  beat address
- bus_data  in  DW  beat data
- rd_en  in  1  read request, honoured only in DONE
- rd_addr  in  AW  read address
- rd_data  out  DW  read data, registered
- rd_valid  out  1  rd_data valid this cycle
- full  out  1  all 2^AW addresses written in the current capture
- cap_count  out  AW+1  distinct addresses written in the current capture
- busy  out  1  state is CAPTURE
- err  out  1  sticky pattern-mismatch flag (CHECK_EN only, else tied 0)
- err_count  out  4  mismatch count, saturating (CHECK_EN only, else tied 0)

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE: bus_valid=1 → CAPTURE. That beat is the first beat of the capture.
- First beat of a capture, from IDLE or DONE:
  - clear the written mask, cap_count, err and err_count;
  - then process the beat as a normal beat.
- Beat processing:
  - mem[bus_addr] ← bus_data;
  - written[bus_addr] ← 1;
  - cap_count increments only if the address was not already written, so a duplicate address overwrites without counting.
- CAPTURE:
  - bus_valid=0 → DONE (generator has released the bus);
  - the beat that makes all addresses written → DONE on the next edge.
- DONE:
  - rd_en=1 → rd_data ← written[rd_addr] ? mem[rd_addr] : 0, and rd_valid ← 1;
  - bus_valid=1 starts a new capture and enters CAPTURE.
- Simultaneous bus_valid and rd_en in DONE: the capture wins, the read is dropped, rd_valid=0.
- rd_en outside DONE is ignored; rd_valid=0.
- full = (cap_count == 2^AW).
- cap_count width AW+1, so it never wraps.

## Timing
- Reset values:
  - state IDLE;
  - rd_data 0, rd_valid 0, full 0, cap_count 0, busy 0, err 0, err_count 0;
  - written mask all 0;
  - mem all 0.
- Beat effects (mem, cap_count, full, err) are visible one cycle after the beat edge.
- Read latency is 1 cycle: rd_valid pulses exactly one cycle per accepted rd_en.
- rst mid-capture or mid-read aborts immediately. All state returns to reset values on that edge, and a beat present on the reset edge is discarded.
- Back-to-back beats are accepted every cycle; there is no backpressure.

## Configuration
- CHECK_EN defined:
  - Each beat is checked: a mismatch occurs if bus_data≠bus_addr, or if the beat is not the first beat and bus_addr≠(previous addr+1) mod 2^AW.
  - A mismatch sets err (sticky until rst or a new capture) and increments err_count, which saturates at 15.
  - The beat is still stored.
- CHECK_EN undefined: no checker logic; err and err_count are constant 0.

## Test plan
- Reset, then 16 beats addr=data=0..15, then bus_valid=0:
  - cap_count=16 and full=1 one cycle after the 16th beat;
  - state DONE;
  - read addr 9 → rd_data=9 and rd_valid=1 one cycle later;
  - err=0.
- 5 beats addr=data=0..4, then bus_valid low:
  - DONE with cap_count=5, full=0;
  - reading addr 10 returns 0.
- (CHECK_EN) beats (0,0),(1,1),(3,3),(4,7):
  - err=1, err_count=2;
  - cap_count=4;
  - reading addr 4 returns 7.
- In DONE, drive rd_en and bus_valid on the same cycle with beat (2,2):
  - rd_valid=0;
  - new capture starts with cap_count=1, and err is cleared.
- Beats (0,0),(0,5): cap_count=1, reading addr 0 returns 5.
- Assert rst after 8 of 16 beats:
  - next cycle all outputs are 0 and state is IDLE;
  - a following 16-beat run reaches full=1 with cap_count=16.

Source files
------------

// File: rtl/bus_sink.sv
// Receiving end of the 4-bit addr/data sequence bus: captures beats into a register file,
// tracks address coverage, and exposes a post-capture read port. Optional checker: CHECK_EN.
module bus_sink #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_valid,
    input  logic [AW-1:0] bus_addr,
    input  logic [DW-1:0] bus_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic [AW:0]   cap_count,
    output logic          busy,
    output logic          err,
    output logic [3:0]    err_count,
    output logic [1:0]    state_dbg
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d, written_base;
    logic [AW:0]       cap_count_q, cap_count_d, cap_base;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              first_beat;

    // Handshake: a beat is taken on every edge where bus_valid=1 (no backpressure);
    // a read is taken when rd_en=1 in DONE with no beat, answered with a one-cycle rd_valid pulse.
    assign first_beat = bus_valid && (state_q != S_CAPTURE);

    always_comb begin
        state_d      = state_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        written_base = first_beat ? '0 : written_q;
        cap_base     = first_beat ? '0 : cap_count_q;
        written_d    = written_base;
        cap_count_d  = cap_base;
        if (bus_valid) begin
            written_d[bus_addr] = 1'b1;
            if (!written_base[bus_addr]) cap_count_d = cap_base + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (bus_valid) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!bus_valid || cap_count_d == FULL_CNT) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus_valid) begin
                    state_d = S_CAPTURE;
                end else if (rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = written_q[rd_addr] ? mem_q[rd_addr] : '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            written_q   <= '0;
            cap_count_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            written_q   <= written_d;
            cap_count_q <= cap_count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            if (bus_valid) mem_q[bus_addr] <= bus_data;
        end
    end

`ifdef CHECK_EN
    logic [AW-1:0] prev_addr_q;
    logic          err_q, err_d;
    logic [3:0]    err_count_q, err_count_d, err_cnt_base;
    logic          mismatch;

    // Sequence rule: data mirrors address, and addresses step by one (wrapping) after the first beat.
    always_comb begin
        mismatch     = 1'b0;
        err_cnt_base = first_beat ? 4'd0 : err_count_q;
        err_d        = first_beat ? 1'b0 : err_q;
        err_count_d  = err_cnt_base;
        if (bus_valid) begin
            mismatch = (bus_data != DW'(bus_addr)) ||
                       (!first_beat && (bus_addr != prev_addr_q + AW'(1)));
            if (mismatch) begin
                err_d = 1'b1;
                if (err_cnt_base != 4'hF) err_count_d = err_cnt_base + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_addr_q <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
            if (bus_valid) prev_addr_q <= bus_addr;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    assign err       = 1'b0;
    assign err_count = 4'd0;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign cap_count = cap_count_q;
    assign full      = (cap_count_q == FULL_CNT);
    assign busy      = (state_q == S_CAPTURE);
    assign state_dbg = state_q;

endmodule
